// File: rtl/draw_background_scroll_if.sv
// draw_background_scroll_if
//   VGA timing bus shared by the draw chain stages.
//   master: the stage that drives the bus; slave: the stage that consumes it.
//   Fields: hsync, vsync, hblnk, vblnk, hcount[10:0], vcount[10:0], rgb[11:0]
//   (VGA_BUS_SIZE = 38 bits when flattened).
interface draw_background_scroll_if;
    localparam int VGA_BUS_SIZE = 38;

    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic [11:0] rgb;

    modport master (output hsync, vsync, hblnk, vblnk, hcount, vcount, rgb);
    modport slave  (input  hsync, vsync, hblnk, vblnk, hcount, vcount, rgb);
endinterface

// File: rtl/draw_background_scroll.sv
// draw_background_scroll
//   Head of the draw chain: fills the active area with a bitmap read from an
//   external synchronous memory, scrolled vertically with wrap-around.
//   Every bus field is delayed by L = MEM_LATENCY + 2 cycles so it lines up
//   with the background colour.
// Ports:
//   pclk, rst      pixel clock, synchronous active-high reset
//   vga_in         timing bus from the timing generator (slave)
//   vga_out        delayed bus carrying the background rgb (master)
//   pix_data       memory read data, valid MEM_LATENCY cycles after address
//   address        registered memory address
//   scroll_en      allow scroll update at the frame boundary
//   scroll_speed   source rows advanced per frame
//   scroll_pos     current scroll offset, 0..IMG_H-1
//   frame_tick     one-cycle pulse on the vblnk rising edge
// Optional build macro:
//   BG_DIAG_LINE_EN  paints 12'hFFF where hcount == vcount (unblanked),
//                    overriding the bitmap; used for geometry alignment.
module draw_background_scroll #(
    parameter int IMG_W       = 400,
    parameter int IMG_H       = 300,
    parameter int SCALE_SHIFT = 1,
    parameter int PIX_BITS    = 4,
    parameter int ADDR_W      = 22,
    parameter int MEM_LATENCY = 1
) (
    input  logic                         pclk,
    input  logic                         rst,
    draw_background_scroll_if.slave      vga_in,
    input  logic [PIX_BITS-1:0]          pix_data,
    input  logic                         scroll_en,
    input  logic [3:0]                   scroll_speed,
    draw_background_scroll_if.master     vga_out,
    output logic [ADDR_W-1:0]            address,
    output logic [$clog2(IMG_H)-1:0]     scroll_pos,
    output logic                         frame_tick
);
    localparam int SPW = $clog2(IMG_H);

    typedef struct packed {
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        in_img;
    } stage_t;

    // pipe[0] is the address stage; pipe[MEM_LATENCY] lines up with pix_data.
    stage_t pipe [MEM_LATENCY+1];
    stage_t out_q;
    logic [11:0] rgb_q;

    // ---------------- address stage ----------------
    logic [31:0]       sx, vy, sy;
    logic              in_img;
    logic [ADDR_W-1:0] addr_next;

    always_comb begin
        sx = 32'(vga_in.hcount >> SCALE_SHIFT);
        vy = 32'(vga_in.vcount >> SCALE_SHIFT);
        sy = vy + 32'(scroll_pos);
        // Both operands are below IMG_H when in range, so one wrap suffices.
        if (sy >= 32'(IMG_H))
            sy = sy - 32'(IMG_H);
        in_img    = (sx < 32'(IMG_W)) && (vy < 32'(IMG_H));
        addr_next = in_img ? ADDR_W'(sy * 32'(IMG_W) + sx) : '0;
    end

    // ---------------- scroll register ----------------
    logic vblnk_q;
    logic armed;   // blocks a spurious edge on the first cycle after reset
    logic vblnk_rise;

    assign vblnk_rise = armed & vga_in.vblnk & ~vblnk_q;

    always_ff @(posedge pclk) begin
        if (rst) begin
            vblnk_q    <= 1'b0;
            armed      <= 1'b0;
            frame_tick <= 1'b0;
            scroll_pos <= '0;
        end else begin
            vblnk_q    <= vga_in.vblnk;
            armed      <= 1'b1;
            frame_tick <= vblnk_rise;
            if (vblnk_rise && scroll_en) begin
                if (32'(scroll_pos) < 32'(scroll_speed))
                    scroll_pos <= SPW'(32'(scroll_pos) + 32'(IMG_H) - 32'(scroll_speed));
                else
                    scroll_pos <= SPW'(32'(scroll_pos) - 32'(scroll_speed));
            end
        end
    end

    // ---------------- pixel expansion ----------------
    logic [11:0] bg_rgb;

    generate
        if (PIX_BITS == 4) begin : g_grey
            assign bg_rgb = {pix_data, pix_data, pix_data};
        end else begin : g_rgb
            assign bg_rgb = 12'(pix_data);
        end
    endgenerate

    logic [11:0] rgb_next;
    stage_t      last;

    assign last = pipe[MEM_LATENCY];

    always_comb begin
        rgb_next = last.in_img ? bg_rgb : 12'h000;
`ifdef BG_DIAG_LINE_EN
        if (last.hcount == last.vcount)
            rgb_next = 12'hFFF;
`endif
        if (last.hblnk || last.vblnk)
            rgb_next = 12'h000;
    end

    // ---------------- delay pipeline ----------------
    always_ff @(posedge pclk) begin
        if (rst) begin
            address <= '0;
            for (int i = 0; i <= MEM_LATENCY; i++)
                pipe[i] <= '0;
            out_q <= '0;
            rgb_q <= '0;
        end else begin
            address <= addr_next;
            pipe[0] <= '{hsync:  vga_in.hsync,
                         vsync:  vga_in.vsync,
                         hblnk:  vga_in.hblnk,
                         vblnk:  vga_in.vblnk,
                         hcount: vga_in.hcount,
                         vcount: vga_in.vcount,
                         in_img: in_img};
            for (int i = 1; i <= MEM_LATENCY; i++)
                pipe[i] <= pipe[i-1];
            out_q <= last;
            rgb_q <= rgb_next;
        end
    end

    assign vga_out.hsync  = out_q.hsync;
    assign vga_out.vsync  = out_q.vsync;
    assign vga_out.hblnk  = out_q.hblnk;
    assign vga_out.vblnk  = out_q.vblnk;
    assign vga_out.hcount = out_q.hcount;
    assign vga_out.vcount = out_q.vcount;
    assign vga_out.rgb    = rgb_q;

    // Incoming rgb is replaced by the background; in_img is not on the bus.
    wire unused_ok = &{1'b0, vga_in.rgb, out_q.in_img};

endmodule
